// File: rtl/byte_striping_tx.sv
// Transmit-side byte striper: round-robins bytes onto four lanes, padding partial groups on flush.
// Define BYTE_STRIPING_TX_ALIGN_EN to release each group as one lane-deskewed 4'hF word.
module byte_striping_tx #(
    parameter logic [7:0] PAD_BYTE = 8'hBC,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [7:0]       data_in,
    input  logic             flush,
    output logic             ready,
    output logic [7:0]       data_out0,
    output logic [7:0]       data_out1,
    output logic [7:0]       data_out2,
    output logic [7:0]       data_out3,
    output logic [3:0]       valid_out,
    output logic [1:0]       lane_ptr,
    output logic [CNT_W-1:0] group_cnt,
    output logic             overflow
);

    typedef enum logic [2:0] {LANE0, LANE1, LANE2, LANE3, PAD} state_t;

    state_t     state;
    logic [1:0] pad_ptr;
    logic [1:0] cur_lane;
    logic       wr_en;
    logic [1:0] wr_lane;
    logic [7:0] wr_byte;

`ifdef BYTE_STRIPING_TX_ALIGN_EN
    logic [7:0] hold [3];
`endif

    // Handshake: a byte transfers on a rising edge where valid_in && ready; valid_in with !ready is dropped.
    always_comb begin
        cur_lane = state[1:0];
        ready    = (state != PAD);
        lane_ptr = (state == PAD) ? pad_ptr : cur_lane;
        wr_en    = 1'b0;
        wr_lane  = cur_lane;
        wr_byte  = data_in;
        if (state == PAD) begin
            wr_en   = 1'b1;
            wr_lane = pad_ptr;
            wr_byte = PAD_BYTE;
        end else begin
            wr_en   = valid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LANE0;
            pad_ptr   <= 2'd0;
            data_out0 <= 8'h00;
            data_out1 <= 8'h00;
            data_out2 <= 8'h00;
            data_out3 <= 8'h00;
            valid_out <= 4'h0;
            group_cnt <= '0;
            overflow  <= 1'b0;
`ifdef BYTE_STRIPING_TX_ALIGN_EN
            hold[0]   <= 8'h00;
            hold[1]   <= 8'h00;
            hold[2]   <= 8'h00;
`endif
        end else begin
            valid_out <= 4'h0;
            if (valid_in && !ready)
                overflow <= 1'b1;

            if (wr_en) begin
                if (wr_lane == 2'd3)
                    group_cnt <= group_cnt + 1'b1;
`ifdef BYTE_STRIPING_TX_ALIGN_EN
                if (wr_lane == 2'd3) begin
                    data_out0 <= hold[0];
                    data_out1 <= hold[1];
                    data_out2 <= hold[2];
                    data_out3 <= wr_byte;
                    valid_out <= 4'hF;
                end else begin
                    hold[wr_lane] <= wr_byte;
                end
`else
                case (wr_lane)
                    2'd0:    data_out0 <= wr_byte;
                    2'd1:    data_out1 <= wr_byte;
                    2'd2:    data_out2 <= wr_byte;
                    default: data_out3 <= wr_byte;
                endcase
                valid_out <= 4'b0001 << wr_lane;
`endif
            end

            // Flush from LANE0 is ignored: there is no partial group to close.
            if (state == PAD) begin
                if (pad_ptr == 2'd3)
                    state <= LANE0;
                else
                    pad_ptr <= pad_ptr + 2'd1;
            end else if (valid_in) begin
                if (cur_lane == 2'd3) begin
                    state <= LANE0;
                end else if (flush && cur_lane != 2'd0) begin
                    state   <= PAD;
                    pad_ptr <= cur_lane + 2'd1;
                end else begin
                    state <= state_t'({1'b0, cur_lane + 2'd1});
                end
            end else if (flush && cur_lane != 2'd0) begin
                state   <= PAD;
                pad_ptr <= cur_lane;
            end
        end
    end

endmodule

// File: tb/tb_byte_striping_tx.sv
// Randomized bench for byte_striping_tx against a stream-position reference model.
// Follows BYTE_STRIPING_TX_ALIGN_EN the same way the design does.
module tb_byte_striping_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        flush;
    logic        ready;
    logic [7:0]  data_out0, data_out1, data_out2, data_out3;
    logic [3:0]  valid_out;
    logic [1:0]  lane_ptr;
    logic [15:0] group_cnt;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: total lane slots written so far and pads still owed.
    int          m_pos;
    int          m_pad;
    logic [7:0]  m_out  [4];
    logic [7:0]  m_hold [4];
    logic [3:0]  m_vld;
    logic [15:0] m_cnt;
    logic        m_ovf;

    byte_striping_tx #(.PAD_BYTE(8'hBC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
        .ready(ready), .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .data_out3(data_out3), .valid_out(valid_out), .lane_ptr(lane_ptr),
        .group_cnt(group_cnt), .overflow(overflow)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_pad = 0;
        m_vld = 4'h0;
        m_cnt = '0;
        m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_out[i]  = 8'h00;
            m_hold[i] = 8'h00;
        end
    endtask

    task automatic emit(input int lane, input logic [7:0] b);
        if (lane == 3) m_cnt = m_cnt + 16'd1;
`ifdef BYTE_STRIPING_TX_ALIGN_EN
        if (lane == 3) begin
            m_out[0] = m_hold[0];
            m_out[1] = m_hold[1];
            m_out[2] = m_hold[2];
            m_out[3] = b;
            m_vld    = 4'hF;
        end else begin
            m_hold[lane] = b;
        end
`else
        m_out[lane] = b;
        m_vld = 4'(1 << lane);
`endif
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic f);
        int start;
        m_vld = 4'h0;
        if (m_pad > 0) begin
            if (v) m_ovf = 1'b1;
            emit(m_pos % 4, 8'hBC);
            m_pos++;
            m_pad--;
        end else begin
            start = m_pos % 4;
            if (v) begin
                emit(start, d);
                m_pos++;
            end
            if (f && start != 0) m_pad = (4 - (m_pos % 4)) % 4;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".d0"}, 32'(data_out0), 32'(m_out[0]));
        check({tag, ".d1"}, 32'(data_out1), 32'(m_out[1]));
        check({tag, ".d2"}, 32'(data_out2), 32'(m_out[2]));
        check({tag, ".d3"}, 32'(data_out3), 32'(m_out[3]));
        check({tag, ".vld"}, 32'(valid_out), 32'(m_vld));
        check({tag, ".ptr"}, 32'(lane_ptr), 32'(m_pos % 4));
        check({tag, ".rdy"}, 32'(ready), 32'(m_pad == 0));
        check({tag, ".cnt"}, 32'(group_cnt), 32'(m_cnt));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Driver: one clock of stimulus, then model update and output comparison.
    task automatic drive(input string tag, input logic v, input logic [7:0] d, input logic f);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk);
        model_step(v, d, f);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle", 1'b0, 8'h00, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        valid_in = 1'b0;
        flush    = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [5];
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        flush    = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) drive("seq5", 1'b1, seq[i], 1'b0);
        check("seq5.cnt_is_1", 32'(group_cnt), 32'd1);
        check("seq5.ptr_is_1", 32'(lane_ptr), 32'd1);
        drive("fl_close", 1'b0, 8'h00, 1'b1);
        idle(4);

        drive("aa", 1'b1, 8'hAA, 1'b0);
        drive("bb", 1'b1, 8'hBB, 1'b0);
        drive("fl_nov", 1'b0, 8'h00, 1'b1);
        idle(3);

        drive("l0", 1'b1, 8'h11, 1'b0);
        drive("fl_v", 1'b1, 8'h33, 1'b1);
        idle(3);
        drive("fl_lane0", 1'b0, 8'h00, 1'b1);
        drive("fl_lane0v", 1'b1, 8'h66, 1'b1);
        drive("l1", 1'b1, 8'h67, 1'b0);
        drive("fl3", 1'b1, 8'h68, 1'b1);
        drive("fl3b", 1'b1, 8'h69, 1'b1);

        drive("pre", 1'b1, 8'hA1, 1'b0);
        drive("pre", 1'b1, 8'hA2, 1'b0);
        drive("fl_ov", 1'b0, 8'h00, 1'b1);
        drive("ov77", 1'b1, 8'h77, 1'b0);
        idle(3);
        check("ovf_sticky", 32'(overflow), 32'd1);

        drive("b3", 1'b1, 8'h01, 1'b0);
        drive("b3", 1'b1, 8'h02, 1'b0);
        drive("b3", 1'b1, 8'h03, 1'b0);
        async_reset("arst");
        drive("after_rst", 1'b1, 8'h5A, 1'b0);
        check("after_rst.ptr_is_1", 32'(lane_ptr), 32'd1);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                async_reset("rnd_arst");
            else
                drive("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_striping_tx.md
# byte_striping_tx

Transmit-side byte striper for the four-lane link. It accepts one byte per cycle from the upstream byte stream and distributes bytes round-robin across lanes 0..3, starting at lane 0. It drives the four lane outputs consumed by the receive-side destriper, which expects byte N on lane N mod 4. A flush request closes a partial group with pad bytes so the lane sequence always stays 4-aligned.

## Interface
Parameters:
- PAD_BYTE, 8'hBC, byte inserted on unfilled lanes during flush
- CNT_W, 16, width of the completed-group counter

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- valid_in  in  1  data_in carries a byte this cycle
- data_in  in  8  upstream byte
- flush  in  1  pad out current partial group (level-sampled)
- ready  out  1  block can accept valid_in this cycle
- data_out0..data_out3  out  8 each  lane data
- valid_out  out  4  per-lane strobe; bit k qualifies data_outk
- lane_ptr  out  2  lane that the next accepted byte will occupy
- group_cnt  out  CNT_W  completed 4-byte groups, including padded groups
- overflow  out  1  sticky; valid_in seen while ready=0

## Operation
- FSM states: LANE0, LANE1, LANE2, LANE3, PAD. lane_ptr = index of the current LANEk state; in PAD it is the lane being padded.
- In LANEk with valid_in=1, the byte is accepted and targets lane k. Next state is LANE(k+1), or LANE0 from LANE3.
- In LANEk with valid_in=0, the state holds.
- Flush applies in LANE1..LANE3:
  - flush=1 and valid_in=0: next state is PAD, padding starts at lane k.
  - flush=1 and valid_in=1: the byte is accepted first. Padding starts at lane k+1 the next cycle. If k=3 the group is complete and there is no PAD.
- flush in LANE0 is ignored; there is no empty group to pad.
- In PAD, ready=0. One PAD_BYTE is emitted per cycle on lanes ptr..3, then the FSM returns to LANE0. flush is ignored while in PAD.
- ready=1 in all LANEk states.
- If valid_in=1 while ready=0, the byte is dropped, overflow sets, and the FSM is unaffected.
- group_cnt increments by one each time lane 3 is written, whether by a data byte or a pad byte. It wraps modulo 2^CNT_W.
- data_outk holds its last value when not strobed. It is not cleared.
- Reset: state LANE0, lane_ptr 0, ready 1, data_out0..3 = 8'h00, valid_out 4'h0, group_cnt 0, overflow 0.
- Reset asserted mid-group or mid-PAD discards the partial group. No pad is emitted.

## Timing
- Non-aligned mode: a byte accepted at rising edge N appears on data_outk with valid_out[k]=1 from edge N to edge N+1. Latency is 1 cycle and at most one valid_out bit is high per cycle.
- PAD cycles strobe exactly like data bytes, one lane per cycle.
- A full back-to-back group takes 4 cycles. A partial group of m bytes followed by flush takes 4 cycles total plus any idle gaps: m data cycles and 4-m pad cycles.
- overflow sets at the edge where the offending valid_in is sampled.

## Configuration
- Macro BYTE_STRIPING_TX_ALIGN_EN.
- Undefined: per-lane strobes as described under Timing.
- Defined: bytes for lanes 0..2, data or pad, go into internal holding registers. At the edge that writes lane 3, all four data_outk update together and valid_out=4'hF for one cycle. No other valid_out pattern is ever produced, so the far end sees a lane-deskewed group. Latency from the lane-3 byte to the output is 1 cycle. Reset also clears the holding registers to 8'h00.

## Test plan
- Reset, then bytes 11,22,33,44,55 on consecutive cycles -> valid_out 1,2,4,8,1. data_out0=11, data_out1=22, data_out2=33, data_out3=44, then data_out0=55. group_cnt=1. lane_ptr=1 after the last byte.
- Bytes AA,BB, then flush with valid_in=0 -> 2 pad cycles with ready=0. data_out2=data_out3=BC. State returns to LANE0 and group_cnt=1.
- flush together with valid_in=1 carrying 33 as the lane-1 byte -> 33 on lane 1, then pads on lanes 2 and 3. flush in LANE0 produces no strobe.
- valid_in=1 with 77 during PAD -> 77 never appears on any lane and overflow=1 until reset.
- Reset asserted asynchronously after 3 bytes, between clock edges -> outputs are zero immediately. The next byte 5A goes to lane 0 and no pad is emitted.
- With BYTE_STRIPING_TX_ALIGN_EN defined, bytes 01,02,03,04 -> valid_out=0 for 3 cycles, then 4'hF with data_out0..3=01,02,03,04 for one cycle. 01,02 plus flush -> 4'hF with 01,02,BC,BC.
